// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing blocks: FSM states and
// width helpers so every SC stage sizes its residue, sum and counters alike.
package sc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sc_state_t;

   // Residue never exceeds N-1, but keep at least one bit for N=2.
   function automatic int res_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   function automatic int sum_width(input int n);
      return $clog2(2 * n);
   endfunction

   function automatic int pop_width(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic int cnt_width(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational ones count over an N-bit vector, shared by the SC blocks.
module sc_popcount
   import sc_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = pop_width(N)
) (
   input  logic [N-1:0]  bits,
   output logic [PW-1:0] count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < N; i++) begin
         count = count + PW'(bits[i]);
      end
   end

endmodule

// File: rtl/sc_sum_n.sv
// N-input scaled stochastic adder: emits a 1 each time the accumulated input
// ones reach N, with framed start/done control and a running ones count.
module sc_sum_n
   import sc_pkg::*;
#(
   parameter  int N        = 2,
   parameter  int LEN      = 256,
   parameter  int INIT_RES = 0,
   localparam int CW       = cnt_width(LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   input  logic [N-1:0]  sn_in,
   output logic          q,
   output logic          out_valid,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] ones_cnt
);

   localparam int RW = res_width(N);
   localparam int SW = sum_width(N);
   localparam int PW = pop_width(N);

   sc_state_t     state;
   logic [RW-1:0] residue;
   logic [CW-1:0] sample_cnt;
   logic [PW-1:0] pop;
   logic [SW-1:0] sum;
   logic          q_next;
   logic [RW-1:0] res_next;

   sc_popcount #(.N(N), .PW(PW)) u_popcount (
      .bits  (sn_in),
      .count (pop)
   );

   // Sum stays below 2N because the residue is always below N.
   always_comb begin
      sum      = SW'(pop) + SW'(residue);
      q_next   = (sum >= SW'(N));
      res_next = q_next ? RW'(sum - SW'(N)) : RW'(sum);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         residue    <= '0;
         sample_cnt <= '0;
         ones_cnt   <= '0;
         q          <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else if (start) begin
         // A start wins over everything, including a sample presented with it.
         state      <= RUN;
         residue    <= RW'(INIT_RES);
         sample_cnt <= '0;
         ones_cnt   <= '0;
         q          <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b1;
         done       <= 1'b0;
      end else begin
         q         <= 1'b0;
         out_valid <= 1'b0;
         done      <= 1'b0;
         case (state)
            RUN: begin
               if (in_valid) begin
                  q         <= q_next;
                  out_valid <= 1'b1;
                  residue   <= res_next;
                  ones_cnt  <= ones_cnt + CW'(q_next);
                  if (sample_cnt == CW'(LEN - 1)) begin
                     state <= DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     sample_cnt <= sample_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_sum_n.sv
// Scoreboard bench for sc_sum_n: three instances cover N=2/LEN=5, N=4/LEN=8
// and N=8/LEN=256 against a reference residue model.
module tb_sc_sum_n;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic       start2 = 1'b0, iv2 = 1'b0;
   logic [1:0] sn2    = '0;
   logic       q2, ov2, busy2, done2;
   logic [2:0] oc2;

   logic       start4 = 1'b0, iv4 = 1'b0;
   logic [3:0] sn4    = '0;
   logic       q4, ov4, busy4, done4;
   logic [3:0] oc4;

   logic       start8 = 1'b0, iv8 = 1'b0;
   logic [7:0] sn8    = '0;
   logic       q8, ov8, busy8, done8;
   logic [8:0] oc8;

   int   n_checks = 0;
   int   n_fail   = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   sc_sum_n #(.N(2), .LEN(5), .INIT_RES(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .in_valid(iv2), .sn_in(sn2),
      .q(q2), .out_valid(ov2), .busy(busy2), .done(done2), .ones_cnt(oc2));

   sc_sum_n #(.N(4), .LEN(8), .INIT_RES(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(iv4), .sn_in(sn4),
      .q(q4), .out_valid(ov4), .busy(busy4), .done(done4), .ones_cnt(oc4));

   sc_sum_n #(.N(8), .LEN(256), .INIT_RES(0)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(iv8), .sn_in(sn8),
      .q(q8), .out_valid(ov8), .busy(busy8), .done(done8), .ones_cnt(oc8));

   function automatic logic model_q(input int n, input int pop, input int res);
      return (pop + res) >= n;
   endfunction

   function automatic int model_res(input int n, input int pop, input int res);
      return ((pop + res) >= n) ? (pop + res - n) : (pop + res);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({q2, ov2, busy2, done2, oc2} !== 7'd0) begin
         n_fail++; $display("[TB] FAIL reset_dut2: got %b expected 0", {q2, ov2, busy2, done2, oc2});
      end
      n_checks++;
      if ({q4, ov4, busy4, done4, oc4} !== 8'd0) begin
         n_fail++; $display("[TB] FAIL reset_dut4: got %b expected 0", {q4, ov4, busy4, done4, oc4});
      end
      n_checks++;
      if ({q8, ov8, busy8, done8, oc8} !== 13'd0) begin
         n_fail++; $display("[TB] FAIL reset_dut8: got %b expected 0", {q8, ov8, busy8, done8, oc8});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_n2_frame();
      logic [1:0] pat [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b01};
      int   res = 0;
      logic eq;
      exp_q.delete();
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      n_checks++;
      if (busy2 !== 1'b1) begin n_fail++; $display("[TB] FAIL n2_busy: got %b expected 1", busy2); end
      for (int cyc = 0; cyc < 6; cyc++) begin
         iv2 = 1'b0;
         if (cyc < 5) begin
            iv2 = 1'b1;
            sn2 = pat[cyc];
            exp_q.push_back(model_q(2, $countones(pat[cyc]), res));
            res = model_res(2, $countones(pat[cyc]), res);
         end
         tick();
         n_checks++;
         if (ov2 !== 1'(cyc < 5)) begin
            n_fail++; $display("[TB] FAIL n2_out_valid[%0d]: got %b expected %b", cyc, ov2, cyc < 5);
         end
         if (ov2 === 1'b1 && exp_q.size() > 0) begin
            eq = exp_q.pop_front();
            n_checks++;
            if (q2 !== eq) begin n_fail++; $display("[TB] FAIL n2_q[%0d]: got %b expected %b", cyc, q2, eq); end
         end
         n_checks++;
         if (done2 !== 1'(cyc == 4)) begin
            n_fail++; $display("[TB] FAIL n2_done[%0d]: got %b expected %b", cyc, done2, cyc == 4);
         end
         if (cyc == 4) begin
            n_checks++;
            if (oc2 !== 3'd2) begin n_fail++; $display("[TB] FAIL n2_ones_cnt: got %0d expected 2", oc2); end
            n_checks++;
            if (busy2 !== 1'b0) begin n_fail++; $display("[TB] FAIL n2_busy_done: got %b expected 0", busy2); end
         end
      end
      iv2 = 1'b0;
   endtask

   task automatic test_n4_levels();
      logic [3:0] v;
      int   res, ones;
      logic eq;
      for (int lv = 0; lv < 2; lv++) begin
         v    = (lv == 1) ? 4'hF : 4'h0;
         res  = 0;
         ones = 0;
         exp_q.delete();
         start4 = 1'b1;
         tick();
         start4 = 1'b0;
         for (int cyc = 0; cyc < 8; cyc++) begin
            iv4 = 1'b1;
            sn4 = v;
            exp_q.push_back(model_q(4, $countones(v), res));
            res  = model_res(4, $countones(v), res);
            ones = ones + $countones(v);
            tick();
            n_checks++;
            if (ov4 !== 1'b1) begin n_fail++; $display("[TB] FAIL lvl_out_valid[%0d]: got %b expected 1", cyc, ov4); end
            if (exp_q.size() > 0) begin
               eq = exp_q.pop_front();
               n_checks++;
               if (q4 !== eq) begin n_fail++; $display("[TB] FAIL lvl_q[%0d]: got %b expected %b", cyc, q4, eq); end
            end
            n_checks++;
            if (done4 !== 1'(cyc == 7)) begin
               n_fail++; $display("[TB] FAIL lvl_done[%0d]: got %b expected %b", cyc, done4, cyc == 7);
            end
         end
         n_checks++;
         if (oc4 !== ((lv == 1) ? 4'd8 : 4'd0)) begin
            n_fail++; $display("[TB] FAIL lvl_ones_cnt[%0d]: got %0d expected %0d", lv, oc4, (lv == 1) ? 8 : 0);
         end
         n_checks++;
         if (oc4 !== 4'(ones / 4)) begin
            n_fail++; $display("[TB] FAIL lvl_floor[%0d]: got %0d expected %0d", lv, oc4, ones / 4);
         end
         iv4 = 1'b0;
         tick();
      end
   endtask

   task automatic test_n4_stalls();
      int   res = 0, ones = 0;
      logic eq, drv;
      exp_q.delete();
      start4 = 1'b1;
      iv4    = 1'b0;
      tick();
      start4 = 1'b0;
      for (int cyc = 0; cyc < 10; cyc++) begin
         drv = !(cyc == 2 || cyc == 5);
         iv4 = drv;
         sn4 = 4'($urandom);
         if (drv) begin
            exp_q.push_back(model_q(4, $countones(sn4), res));
            res  = model_res(4, $countones(sn4), res);
            ones = ones + $countones(sn4);
         end
         tick();
         n_checks++;
         if (ov4 !== drv) begin n_fail++; $display("[TB] FAIL stall_out_valid[%0d]: got %b expected %b", cyc, ov4, drv); end
         if (ov4 === 1'b1 && exp_q.size() > 0) begin
            eq = exp_q.pop_front();
            n_checks++;
            if (q4 !== eq) begin n_fail++; $display("[TB] FAIL stall_q[%0d]: got %b expected %b", cyc, q4, eq); end
         end
         n_checks++;
         if (done4 !== 1'(cyc == 9)) begin
            n_fail++; $display("[TB] FAIL stall_done[%0d]: got %b expected %b", cyc, done4, cyc == 9);
         end
      end
      n_checks++;
      if (oc4 !== 4'(ones / 4)) begin n_fail++; $display("[TB] FAIL stall_ones_cnt: got %0d expected %0d", oc4, ones / 4); end
      iv4 = 1'b0;
      tick();
   endtask

   task automatic test_restart();
      int   res = 0, ones = 0;
      logic eq;
      exp_q.delete();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         iv4 = 1'b1;
         sn4 = 4'($urandom);
         exp_q.push_back(model_q(4, $countones(sn4), res));
         res = model_res(4, $countones(sn4), res);
         tick();
         if (exp_q.size() > 0) begin
            eq = exp_q.pop_front();
            n_checks++;
            if (q4 !== eq) begin n_fail++; $display("[TB] FAIL rst_part_q[%0d]: got %b expected %b", cyc, q4, eq); end
         end
      end
      start4 = 1'b1;
      iv4    = 1'b1;
      sn4    = 4'hF;
      tick();
      start4 = 1'b0;
      n_checks++;
      if ({ov4, done4, oc4} !== 6'd0) begin
         n_fail++; $display("[TB] FAIL restart_clear: got %b expected 0", {ov4, done4, oc4});
      end
      n_checks++;
      if (busy4 !== 1'b1) begin n_fail++; $display("[TB] FAIL restart_busy: got %b expected 1", busy4); end
      res = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 8; cyc++) begin
         iv4 = 1'b1;
         sn4 = 4'($urandom);
         exp_q.push_back(model_q(4, $countones(sn4), res));
         res  = model_res(4, $countones(sn4), res);
         ones = ones + $countones(sn4);
         tick();
         if (exp_q.size() > 0) begin
            eq = exp_q.pop_front();
            n_checks++;
            if (q4 !== eq) begin n_fail++; $display("[TB] FAIL restart_q[%0d]: got %b expected %b", cyc, q4, eq); end
         end
         n_checks++;
         if (done4 !== 1'(cyc == 7)) begin
            n_fail++; $display("[TB] FAIL restart_done[%0d]: got %b expected %b", cyc, done4, cyc == 7);
         end
      end
      n_checks++;
      if (oc4 !== 4'(ones / 4)) begin n_fail++; $display("[TB] FAIL restart_ones_cnt: got %0d expected %0d", oc4, ones / 4); end
      iv4 = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_run();
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         iv4 = 1'b1;
         sn4 = 4'hF;
         tick();
      end
      n_checks++;
      if ({q4, ov4, busy4, oc4} !== {3'b111, 4'd3}) begin
         n_fail++; $display("[TB] FAIL midrst_pre: got %b expected %b", {q4, ov4, busy4, oc4}, {3'b111, 4'd3});
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({q4, ov4, busy4, done4, oc4} !== 8'd0) begin
         n_fail++; $display("[TB] FAIL midrst_async: got %b expected 0", {q4, ov4, busy4, done4, oc4});
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 3; cyc++) begin
         tick();
         n_checks++;
         if ({ov4, busy4, oc4} !== 6'd0) begin
            n_fail++; $display("[TB] FAIL midrst_idle[%0d]: got %b expected 0", cyc, {ov4, busy4, oc4});
         end
      end
      iv4 = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      int   res = 0, cnt = 0, ones = 0, frames = 0, budget = 0;
      logic model_run, sampled, last, eq, chained;
      exp_q.delete();
      start8 = 1'b1;
      iv8    = 1'b1;
      sn8    = 8'hFF;
      tick();
      start8    = 1'b0;
      model_run = 1'b1;
      while (frames < 2 && budget < 2000) begin
         budget++;
         chained = start8;
         iv8     = ($urandom_range(0, 9) != 0);
         sn8     = 8'($urandom);
         sampled = iv8 && model_run && !start8;
         last    = 1'b0;
         if (start8) begin
            res = 0; cnt = 0; ones = 0; model_run = 1'b1;
         end else if (sampled) begin
            exp_q.push_back(model_q(8, $countones(sn8), res));
            res  = model_res(8, $countones(sn8), res);
            ones = ones + $countones(sn8);
            cnt++;
            last = (cnt == 256);
            if (last) model_run = 1'b0;
         end
         tick();
         start8 = 1'b0;
         n_checks++;
         if (ov8 !== sampled) begin n_fail++; $display("[TB] FAIL b2b_out_valid[%0d]: got %b expected %b", budget, ov8, sampled); end
         if (ov8 === 1'b1 && exp_q.size() > 0) begin
            eq = exp_q.pop_front();
            n_checks++;
            if (q8 !== eq) begin n_fail++; $display("[TB] FAIL b2b_q[%0d]: got %b expected %b", budget, q8, eq); end
         end
         n_checks++;
         if (dut8.residue !== 3'(res)) begin
            n_fail++; $display("[TB] FAIL b2b_residue[%0d]: got %0d expected %0d", budget, dut8.residue, res);
         end
         n_checks++;
         if (done8 !== last) begin n_fail++; $display("[TB] FAIL b2b_done[%0d]: got %b expected %b", budget, done8, last); end
         if (chained) begin
            n_checks++;
            if ({busy8, oc8} !== {1'b1, 9'd0}) begin
               n_fail++; $display("[TB] FAIL b2b_chain: got %b expected %b", {busy8, oc8}, {1'b1, 9'd0});
            end
         end
         if (last) begin
            n_checks++;
            if (oc8 !== 9'(ones / 8)) begin
               n_fail++; $display("[TB] FAIL b2b_ones_cnt[%0d]: got %0d expected %0d", frames, oc8, ones / 8);
            end
            frames++;
            if (frames < 2) start8 = 1'b1;
         end
      end
      if (frames < 2) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL b2b_timeout: got %0d frames expected 2", frames);
      end
      iv8 = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_n2_frame();
      test_n4_levels();
      test_n4_stalls();
      test_restart();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
